// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared widths and reset values for the fetch stage
package ifetch_pkg;

  // Word-address width, matching the imem address port.
  localparam int DEF_ADDR_W = 16;

  // Instruction width.
  localparam int DEF_DATA_W = 32;

  // Fetch-queue entries; power of two, at least 2.
  localparam int DEF_FQ_DEPTH = 2;

  // PC loaded on reset.
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

  // Occupancy counter width for a queue of the given depth.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - fetch-to-decode valid/ready handshake
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;

  // Fetch side: presents the queue head.
  modport master (
    output id_valid,
    output id_instr,
    output id_pc,
    input  id_ready
  );

  // Decode side: consumes the queue head.
  modport slave (
    input  id_valid,
    input  id_instr,
    input  id_pc,
    output id_ready
  );

endinterface

// File: rtl/ifetch_fetch_fifo.sv
// rtl/ifetch_fetch_fifo.sv - synchronous fetch queue with flush and unregistered head
module fetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is read straight from storage; an empty queue reads as zero.
  assign head = empty ? '0 : mem[rptr];

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      if (do_push && !do_pop)
        count <= count + CNT_W'(1);
      else if (do_pop && !do_push)
        count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, imem address, fetch queue, redirect
module ifetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                FQ_DEPTH = DEF_FQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         imem_a,
  input  logic [DATA_W-1:0]         imem_rd,
  input  logic                      halt,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  ifetch_if.master                  dec,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int ENTRY_W = DATA_W + ADDR_W;

  logic [ADDR_W-1:0]  pc_q;
  logic [ENTRY_W-1:0] head;
  logic               fq_full;
  logic               fq_empty;
  logic               enq;
  logic               deq;

  // Enqueue depends only on registered state and halt/redirect, never on
  // id_ready, so a same-cycle dequeue cannot open a slot in a full queue.
  assign enq = !halt && !redirect && !fq_full;
  assign deq = dec.id_valid && dec.id_ready;

  // imem is addressed straight from the PC register.
  assign imem_a = pc_q;

  assign dec.id_valid = !fq_empty;
  assign dec.id_instr = head[ENTRY_W-1:ADDR_W];
  assign dec.id_pc    = head[ADDR_W-1:0];

  // PC register: redirect overrides fetch advance; wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst)
      pc_q <= RESET_PC;
    else if (redirect)
      pc_q <= redirect_pc;
    else if (enq)
      pc_q <= pc_q + ADDR_W'(1);
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (enq),
    .pop   (deq),
    .wdata ({imem_rd, pc_q}),
    .head  (head),
    .count (fq_count),
    .full  (fq_full),
    .empty (fq_empty)
  );

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for the fetch stage
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic [15:0] imem_a;
  logic [31:0] imem_rd;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [1:0]  fq_count;

  int n_checks;
  int n_fail;

  ifetch_if #(.ADDR_W(16), .DATA_W(32)) dec ();

  ifetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_a      (imem_a),
    .imem_rd     (imem_rd),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec         (dec),
    .fq_count    (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 32'h80020000;
      16'h0001: mem_word = 32'h80030001;
      16'h0002: mem_word = 32'h20040003;
      default:  mem_word = {16'hC0DE, a};
    endcase
  endfunction

  assign imem_rd = mem_word(imem_a);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [15:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, {63'd0, dec.id_valid}, 64'd1);
    check({tag, "_pc"}, {48'd0, dec.id_pc}, {48'd0, pc});
    check({tag, "_instr"}, {32'd0, dec.id_instr}, {32'd0, instr});
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {63'd0, dec.id_valid}, 64'd0);
    check({tag, "_count"}, {62'd0, fq_count}, 64'd0);
    check({tag, "_instr"}, {32'd0, dec.id_instr}, 64'd0);
    check({tag, "_pc"}, {48'd0, dec.id_pc}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    halt         = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 16'h0000;
    dec.id_ready = 1'b1;

    // 1: reset then free-run
    do_reset();
    check_empty("rst");
    check("rst_imem_a", {48'd0, imem_a}, 64'd0);
    tick();
    check_head("run0", 16'h0000, 32'h80020000);
    check("run0_count", {62'd0, fq_count}, 64'd1);
    tick();
    check_head("run1", 16'h0001, 32'h80030001);
    tick();
    check_head("run2", 16'h0002, 32'h20040003);
    check("run2_count", {62'd0, fq_count}, 64'd1);

    // 2: backpressure
    dec.id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("bp_count", {62'd0, fq_count}, 64'd2);
    check("bp_imem_a", {48'd0, imem_a}, 64'd2);
    check_head("bp_head", 16'h0000, 32'h80020000);
    dec.id_ready = 1'b1;
    tick();
    check_head("bp_res1", 16'h0001, 32'h80030001);
    check("bp_res1_count", {62'd0, fq_count}, 64'd1);
    tick();
    check_head("bp_res2", 16'h0002, 32'h20040003);

    // 3: redirect while queue holds PCs 3 and 4
    tick();
    check_head("rd_pre3", 16'h0003, 32'hC0DE0003);
    dec.id_ready = 1'b0;
    tick();
    check("rd_pre_count", {62'd0, fq_count}, 64'd2);
    check_head("rd_pre_head", 16'h0003, 32'hC0DE0003);
    redirect    = 1'b1;
    redirect_pc = 16'h000C;
    tick();
    redirect = 1'b0;
    check_empty("rd_flush");
    check("rd_imem_a", {48'd0, imem_a}, 64'h000C);
    dec.id_ready = 1'b1;
    tick();
    check_head("rd_new", 16'h000C, 32'hC0DE000C);

    // 4: redirect with a full queue and id_ready=1
    dec.id_ready = 1'b0;
    tick();
    check("rf_full", {62'd0, fq_count}, 64'd2);
    dec.id_ready = 1'b1;
    redirect     = 1'b1;
    redirect_pc  = 16'h0040;
    tick();
    redirect = 1'b0;
    check_empty("rf_flush");
    check("rf_imem_a", {48'd0, imem_a}, 64'h0040);
    tick();
    check_head("rf_new", 16'h0040, 32'hC0DE0040);

    // 5: halt drains the queue and holds the PC
    dec.id_ready = 1'b0;
    tick();
    check("h_pre_count", {62'd0, fq_count}, 64'd2);
    halt         = 1'b1;
    dec.id_ready = 1'b1;
    tick();
    check("h1_imem_a", {48'd0, imem_a}, 64'h0042);
    check_head("h1", 16'h0041, 32'hC0DE0041);
    tick();
    check("h2_imem_a", {48'd0, imem_a}, 64'h0042);
    tick();
    check("h3_imem_a", {48'd0, imem_a}, 64'h0042);
    check_empty("h3");
    halt = 1'b0;
    tick();
    check_head("h_resume", 16'h0042, 32'hC0DE0042);

    // 6: PC wrap, then reset with two entries queued
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    check("w_imem_a", {48'd0, imem_a}, 64'hFFFF);
    tick();
    check_head("w0", 16'hFFFF, 32'hC0DEFFFF);
    check("w0_imem_a", {48'd0, imem_a}, 64'h0000);
    tick();
    check_head("w1", 16'h0000, 32'h80020000);
    tick();
    check_head("w2", 16'h0001, 32'h80030001);
    dec.id_ready = 1'b0;
    tick();
    check("w_full", {62'd0, fq_count}, 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_empty("mid_rst");
    check("mid_rst_imem_a", {48'd0, imem_a}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
